uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Parametrised UART receiver, successor to the single-word RX.
//  - Configurable data bits, parity mode and stop bits.
//  - 3-sample majority vote per bit; false-start rejection.
//  - Framing, parity, break and overrun detection.
//  - Small output FIFO so the bus side need not read each word immediately.
//  Sits between the pad (RX_DSER) and the bus/register block; bit timing comes from the baud generator (DIVPULSE).
// PARAMETERS
//  OVERSAMPLING  16  DIVPULSE ticks per bit; even, >=4
//  DATA_BITS     8   data bits per frame, 5..9, LSB first
//  PARITY        0   0=none, 1=odd, 2=even
//  STOP_BITS     1   stop bits expected, 1 or 2
//  FIFO_DEPTH    4   RX words buffered; power of 2, >=2
// PORTS
//  CLK         in   1          system clock
//  NRST        in   1          reset; asynchronous, active-low
//  DIVPULSE    in   1          1-CLK oversample tick from baud generator
//  RX_DSER     in   1          serial line, asynchronous to CLK
//  RX_RD       in   1          pop FIFO head (ignored when RX_DRDY=0)
//  RX_OVR_CLR  in   1          clear sticky overrun flag
//  RX_DO       out  DATA_BITS  FIFO head data, valid while RX_DRDY=1
//  RX_PERR     out  1          parity error of head word (0 if PARITY=0)
//  RX_FERR     out  1          framing error of head word
//  RX_DRDY     out  1          FIFO not empty
//  RX_OVR      out  1          sticky: a word was dropped, FIFO full
//  RX_BREAK    out  1          1-CLK pulse on break detection
//  RX_BUSY     out  1          1 while state != S_IDLE
// BEHAVIOUR
//  Reset: async on NRST=0.
//  - All outputs 0; FIFO emptied; state S_IDLE; counters 0.
//  - Synchroniser (2 FF) set to 1.
//  - Partial frame discarded. Applies mid-frame too.
//  Sampling: RX_DSER through 2-FF sync; all FSM/counter updates only on CLK edges with DIVPULSE=1.
//  tick cnt 0..OVERSAMPLING-1; M=OVERSAMPLING/2.
//  - Samples taken at cnt=M-1, M, M+1; bit value = majority of the 3.
//  - Non-final bit period ends at cnt=OVERSAMPLING-1; cnt wraps to 0.
//  FSM:
//  - S_IDLE: synced line 0 on a tick -> S_START, cnt=0 (this tick = tick 0).
//  - S_START: at cnt=M+1, vote=1 -> S_IDLE (false start, no word).
//      Vote=0 -> continue to period end, then S_DATA.
//  - S_DATA: DATA_BITS periods, bit i -> shift[i].
//      -> S_PAR if PARITY!=0, else S_STOP.
//  - S_PAR: one period.
//      perr = (^data ^ pbit) != (PARITY==1).
//  - S_STOP: STOP_BITS periods; ferr=1 if any stop vote is 0.
//      Last stop bit ends at cnt=M+1 (half-bit resync margin): push {perr,ferr,data}.
//      ferr=0 -> S_IDLE; ferr=1 -> S_WAIT_HI.
//  - S_WAIT_HI: stay until synced line 1 on a tick, then S_IDLE.
//      Blocks re-triggering on a held-low line.
//  Break: data==0, parity bit (if any)==0 and ferr=1.
//  - Word still pushed (data 0, FERR=1).
//  - RX_BREAK pulses 1 CLK, same cycle as push.
//  FIFO:
//  - Push visible as RX_DRDY=1 on the CLK after the final stop sample.
//  - Pop on RX_RD&RX_DRDY; next head on the following CLK.
//  - Pointers wrap mod FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
//  - Push while full and no pop: word dropped, RX_OVR<=1.
//  - Push+pop same CLK when full: both succeed, no overrun.
//  - Push+pop same CLK when empty: pop ignored, word stored.
//  - RX_OVR held until RX_OVR_CLR; set wins over clear in the same CLK.
//  - No DIVPULSE: FSM frozen; FIFO pop still works.
// TESTING
//  - 8N1, OS=16, send 0xA5 -> one word 0xA5, PERR=0, FERR=0; RX_BUSY low after frame.
//  - PARITY=2, send 0x03: pbit=1 -> PERR=1; pbit=0 -> PERR=0.
//      PARITY=1, 0x03 pbit=1 -> PERR=0.
//  - Line low for 3 ticks then high -> no word, S_IDLE.
//      1-tick low spike at cnt=M inside a '1' data bit of 0xFF -> 0xFF received.
//  - FIFO_DEPTH=4: send 0x11..0x55 without RX_RD -> RX_OVR=1.
//      Reads give 0x11,0x22,0x33,0x44, then RX_DRDY=0; RX_OVR_CLR -> RX_OVR=0.
//  - Hold line low 2 frame times -> exactly one word 0x00 with FERR=1, one RX_BREAK pulse.
//      Release high, send 0x5A -> 0x5A, FERR=0.
//  - Pulse NRST low during data bit 3 -> all outputs 0 immediately.
//      Next frame 0x3C received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampling UART receiver with majority vote, error flags and RX FIFO
module uart_rx_fifo #(
    parameter int OVERSAMPLING = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 CLK,
    input  logic                 NRST,
    input  logic                 DIVPULSE,
    input  logic                 RX_DSER,
    input  logic                 RX_RD,
    input  logic                 RX_OVR_CLR,
    output logic [DATA_BITS-1:0] RX_DO,
    output logic                 RX_PERR,
    output logic                 RX_FERR,
    output logic                 RX_DRDY,
    output logic                 RX_OVR,
    output logic                 RX_BREAK,
    output logic                 RX_BUSY
);

    localparam int CW = $clog2(OVERSAMPLING);
    localparam int M  = OVERSAMPLING / 2;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = DATA_BITS + 2;

    localparam logic [CW-1:0] C_S0   = CW'(M - 1);
    localparam logic [CW-1:0] C_S1   = CW'(M);
    localparam logic [CW-1:0] C_VOTE = CW'(M + 1);
    localparam logic [CW-1:0] C_END  = CW'(OVERSAMPLING - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_WAIT_HI
    } state_t;

    state_t                r_state, w_state_n;
    logic                  r_sync1, r_sync2;
    logic                  r_s0, r_s1;
    logic [CW-1:0]         r_cnt, w_cnt_n, w_cur;
    logic [3:0]            r_bit, w_bit_n;
    logic [DATA_BITS-1:0]  r_shift, w_shift_n;
    logic                  r_pbit, w_pbit_n;
    logic                  r_ferr, w_ferr_n;
    logic                  w_vote, w_active, w_push, w_perr, w_break;

    logic [WW-1:0]         r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  r_ovr, r_break;
    logic                  w_pop, w_full, w_wr, w_ovf;
    logic [WW-1:0]         w_head;

    // r_cnt holds the index of the last processed tick; w_cur is the index of the current one
    assign w_cur    = (r_cnt == C_END) ? '0 : r_cnt + 1'b1;
    assign w_vote   = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
    assign w_active = (r_state != S_IDLE) && (r_state != S_WAIT_HI);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_pbit_n  = r_pbit;
        w_ferr_n  = r_ferr;
        w_push    = 1'b0;
        if (DIVPULSE) begin
            if (w_active)
                w_cnt_n = w_cur;
            case (r_state)
                S_IDLE: begin
                    if (!r_sync2) begin
                        w_state_n = S_START;
                        w_cnt_n   = '0;
                        w_bit_n   = '0;
                        w_ferr_n  = 1'b0;
                    end
                end
                S_START: begin
                    if (w_cur == C_VOTE && w_vote)
                        w_state_n = S_IDLE;
                    else if (w_cur == C_END)
                        w_state_n = S_DATA;
                end
                S_DATA: begin
                    if (w_cur == C_VOTE)
                        w_shift_n = {w_vote, r_shift[DATA_BITS-1:1]};
                    if (w_cur == C_END) begin
                        if (r_bit == LAST_DATA) begin
                            w_bit_n   = '0;
                            w_state_n = (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            w_bit_n = r_bit + 1'b1;
                        end
                    end
                end
                S_PAR: begin
                    if (w_cur == C_VOTE)
                        w_pbit_n = w_vote;
                    if (w_cur == C_END)
                        w_state_n = S_STOP;
                end
                S_STOP: begin
                    // last stop bit closes at mid-bit so the next start edge is not missed
                    if (w_cur == C_VOTE) begin
                        w_ferr_n = r_ferr | ~w_vote;
                        if (r_bit == LAST_STOP) begin
                            w_push    = 1'b1;
                            w_state_n = w_ferr_n ? S_WAIT_HI : S_IDLE;
                        end
                    end else if (w_cur == C_END) begin
                        w_bit_n = r_bit + 1'b1;
                    end
                end
                S_WAIT_HI: begin
                    if (r_sync2)
                        w_state_n = S_IDLE;
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    assign w_perr  = (PARITY != 0) && ((^r_shift ^ r_pbit) != (PARITY == 1));
    assign w_break = w_push && (r_shift == '0) && ((PARITY == 0) || !r_pbit) && w_ferr_n;

    assign w_pop  = RX_RD && (r_count != '0);
    assign w_full = (r_count == FULL_CNT);
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_ovf  = w_push && w_full && !w_pop;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_pbit   <= 1'b0;
            r_ferr   <= 1'b0;
            r_s0     <= 1'b0;
            r_s1     <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovr    <= 1'b0;
            r_break  <= 1'b0;
        end else begin
            r_sync1 <= RX_DSER;
            r_sync2 <= r_sync1;
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_pbit  <= w_pbit_n;
            r_ferr  <= w_ferr_n;
            if (DIVPULSE && w_active) begin
                if (w_cur == C_S0) r_s0 <= r_sync2;
                if (w_cur == C_S1) r_s1 <= r_sync2;
            end
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_ovf)
                r_ovr <= 1'b1;
            else if (RX_OVR_CLR)
                r_ovr <= 1'b0;
            r_break <= w_break;
        end
    end

    // storage needs no reset: every head output is gated by RX_DRDY
    always_ff @(posedge CLK) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= {w_perr, w_ferr_n, r_shift};
    end

    assign w_head   = r_mem[r_rd_ptr];
    assign RX_DRDY  = (r_count != '0);
    assign RX_DO    = RX_DRDY ? w_head[DATA_BITS-1:0] : '0;
    assign RX_FERR  = RX_DRDY & w_head[DATA_BITS];
    assign RX_PERR  = RX_DRDY & w_head[DATA_BITS+1];
    assign RX_OVR   = r_ovr;
    assign RX_BREAK = r_break;
    assign RX_BUSY  = (r_state != S_IDLE);

endmodule
